// File: rtl/ccc_lock_sequencer.sv
// CCC/PLL lock sequencer and single-byte APB configuration master, clocked from the RC oscillator.
// Define CCC_SEQ_RETRY_EN to retry the PLL reset up to MAX_RETRIES times before declaring FAULT.
module ccc_lock_sequencer #(
  parameter int unsigned ARST_CYCLES         = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 17
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       LOCK,
  output logic       PLL_ARST_N,
  output logic       PLL_POWERDOWN_N,
  output logic       PRESET_N,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       CFG_REQ,
  input  logic [5:0] CFG_ADDR,
  input  logic [7:0] CFG_DATA,
  output logic       CFG_ACK,
  output logic       FAB_RESET_N,
  output logic       READY,
  output logic       FAULT,
  output logic [7:0] LOSS_CNT
);

  typedef enum logic [2:0] {
    StPllRst, StWaitLock, StStable, StRun, StCfgSetup, StCfgAccess, StFault
  } state_e;

  localparam logic [CNT_W-1:0] ArstCnt     = CNT_W'(ARST_CYCLES);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  // The retry count is carried in 8 bits; the counter must hold the largest cycle count.
  if (MAX_RETRIES > 255 || CNT_W < $clog2(LOCK_TIMEOUT_CYCLES + 1)) begin : g_bad_params
    $error("ccc_lock_sequencer: parameter out of range");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lock_meta_q, lock_s_q;
`ifdef CCC_SEQ_RETRY_EN
  logic [7:0]       retry_q;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= StPllRst;
      cnt_q           <= '0;
      PLL_ARST_N      <= 1'b0;
      PLL_POWERDOWN_N <= 1'b1;
      PRESET_N        <= 1'b0;
      PSEL            <= 1'b0;
      PENABLE         <= 1'b0;
      PWRITE          <= 1'b0;
      PADDR           <= '0;
      PWDATA          <= '0;
      CFG_ACK         <= 1'b0;
      FAB_RESET_N     <= 1'b0;
      READY           <= 1'b0;
      FAULT           <= 1'b0;
      LOSS_CNT        <= '0;
`ifdef CCC_SEQ_RETRY_EN
      retry_q         <= '0;
`endif
    end else begin
      PRESET_N        <= 1'b1;
      PLL_POWERDOWN_N <= 1'b1;
      CFG_ACK         <= 1'b0;
      case (state_q)
        StPllRst: begin
          if (cnt_q == ArstCnt) begin
            PLL_ARST_N <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StWaitLock;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWaitLock: begin
          if (lock_s_q) begin
            cnt_q   <= '0;
            state_q <= StStable;
          end else if (cnt_q == TimeoutLast) begin
`ifdef CCC_SEQ_RETRY_EN
            if (retry_q < 8'(MAX_RETRIES)) begin
              retry_q    <= retry_q + 8'd1;
              PLL_ARST_N <= 1'b0;
              cnt_q      <= CNT_W'(1);
              state_q    <= StPllRst;
            end else begin
              FAULT      <= 1'b1;
              PLL_ARST_N <= 1'b0;
              state_q    <= StFault;
            end
`else
            FAULT      <= 1'b1;
            PLL_ARST_N <= 1'b0;
            state_q    <= StFault;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StStable: begin
          if (!lock_s_q) begin
            cnt_q   <= '0;
            state_q <= StWaitLock;
          end else if (cnt_q == StableLast) begin
            READY       <= 1'b1;
            FAB_RESET_N <= 1'b1;
            state_q     <= StRun;
`ifdef CCC_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          // Lock loss has priority; a concurrent request stays pending until the next RUN.
          if (!lock_s_q) begin
            READY       <= 1'b0;
            FAB_RESET_N <= 1'b0;
            if (LOSS_CNT != 8'hFF) LOSS_CNT <= LOSS_CNT + 8'd1;
            cnt_q       <= '0;
            state_q     <= StWaitLock;
          end else if (CFG_REQ) begin
            READY       <= 1'b0;
            FAB_RESET_N <= 1'b0;
            PSEL        <= 1'b1;
            PWRITE      <= 1'b1;
            PENABLE     <= 1'b0;
            PADDR       <= CFG_ADDR;
            PWDATA      <= CFG_DATA;
            state_q     <= StCfgSetup;
          end
        end
        StCfgSetup: begin
          PENABLE <= 1'b1;
          state_q <= StCfgAccess;
        end
        StCfgAccess: begin
          // Entry into PLL_RST counts as the first low cycle of the relock pulse.
          PSEL       <= 1'b0;
          PENABLE    <= 1'b0;
          PWRITE     <= 1'b0;
          CFG_ACK    <= 1'b1;
          PLL_ARST_N <= 1'b0;
          cnt_q      <= CNT_W'(1);
          state_q    <= StPllRst;
        end
        StFault: state_q <= StFault;
        default: state_q <= StPllRst;
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// Directed bench for ccc_lock_sequencer with shortened cycle-count parameters.
// Expected values follow CCC_SEQ_RETRY_EN the same way the design does.
module tb_ccc_lock_sequencer;
  localparam int A = 4;   // ARST_CYCLES
  localparam int S = 8;   // LOCK_STABLE_CYCLES
  localparam int T = 32;  // LOCK_TIMEOUT_CYCLES
  localparam int R = 3;   // MAX_RETRIES
  localparam logic [31:0] RstVec = 32'h4000_0000;

  logic       CLK = 1'b0;
  logic       RESET_N, LOCK, CFG_REQ;
  logic [5:0] CFG_ADDR;
  logic [7:0] CFG_DATA;
  logic       PLL_ARST_N, PLL_POWERDOWN_N, PRESET_N, PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;
  logic       CFG_ACK, FAB_RESET_N, READY, FAULT;
  logic [7:0] LOSS_CNT;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ccc_lock_sequencer #(
    .ARST_CYCLES(A), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(R), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LOCK(LOCK), .PLL_ARST_N(PLL_ARST_N),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .PRESET_N(PRESET_N), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .CFG_REQ(CFG_REQ), .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA), .CFG_ACK(CFG_ACK), .FAB_RESET_N(FAB_RESET_N), .READY(READY),
    .FAULT(FAULT), .LOSS_CNT(LOSS_CNT)
  );

  function automatic logic [31:0] out_vec();
    return {PLL_ARST_N, PLL_POWERDOWN_N, PRESET_N, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
            CFG_ACK, FAB_RESET_N, READY, FAULT, LOSS_CNT};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin tick(); n++; end while (READY !== 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; LOCK = 1'b0; CFG_REQ = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    tick(); tick();
    n_cmp++; if (out_vec() !== RstVec) begin
      n_err++; $display("FAIL reset_vec: got %h want %h", out_vec(), RstVec); end
    n_cmp++; if (PLL_POWERDOWN_N !== 1'b1) begin
      n_err++; $display("FAIL reset_pd: got %b want 1", PLL_POWERDOWN_N); end
    n_cmp++; if (PLL_ARST_N !== 1'b0) begin
      n_err++; $display("FAIL reset_arst: got %b want 0", PLL_ARST_N); end
  endtask

  task automatic test_cold_start();
    int n;
    RESET_N = 1'b1;
    tick(); n = 1;
    n_cmp++; if (PRESET_N !== 1'b1) begin
      n_err++; $display("FAIL preset_rise: got %b want 1", PRESET_N); end
    while (PLL_ARST_N !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== A + 1) begin
      n_err++; $display("FAIL arst_rise_edges: got %0d want %0d", n, A + 1); end
    repeat (10) tick();
    LOCK = 1'b1;
    wait_ready(n);
    n_cmp++; if (n !== S + 3) begin
      n_err++; $display("FAIL cold_ready_edges: got %0d want %0d", n, S + 3); end
    n_cmp++; if (FAB_RESET_N !== 1'b1) begin
      n_err++; $display("FAIL cold_fab: got %b want 1", FAB_RESET_N); end
    n_cmp++; if (LOSS_CNT !== 8'd0) begin
      n_err++; $display("FAIL cold_loss: got %0d want 0", LOSS_CNT); end
  endtask

  task automatic test_lock_loss();
    int n;
    LOCK = 1'b0; n = 0;
    do begin tick(); n++; end while (FAB_RESET_N !== 1'b0 && n < 20);
    n_cmp++; if (n !== 3) begin
      n_err++; $display("FAIL loss_fab_edges: got %0d want 3", n); end
    n_cmp++; if (LOSS_CNT !== 8'd1 || READY !== 1'b0) begin
      n_err++; $display("FAIL loss_cnt: got %0d/%b want 1/0", LOSS_CNT, READY); end
    LOCK = 1'b1;
    wait_ready(n);
    n_cmp++; if (n !== S + 3) begin
      n_err++; $display("FAIL loss_relock_edges: got %0d want %0d", n, S + 3); end
  endtask

  task automatic test_dropout();
    int n;
    LOCK = 1'b0; repeat (3) tick();
    LOCK = 1'b1; repeat (3) tick();  // now in STABLE
    repeat (4) tick();
    LOCK = 1'b0; tick();
    LOCK = 1'b1;
    wait_ready(n);
    n_cmp++; if (n !== S + 3) begin
      n_err++; $display("FAIL dropout_ready_edges: got %0d want %0d", n, S + 3); end
    n_cmp++; if (LOSS_CNT !== 8'd2) begin
      n_err++; $display("FAIL dropout_loss: got %0d want 2", LOSS_CNT); end
  endtask

  task automatic test_config();
    int n;
    CFG_ADDR = 6'h2A; CFG_DATA = 8'h5C; CFG_REQ = 1'b1;
    tick();
    n_cmp++; if ({PSEL, PWRITE, PENABLE, PADDR, PWDATA} !== {3'b110, 6'h2A, 8'h5C}) begin
      n_err++; $display("FAIL cfg_setup: got %b%b%b %h %h want 110 2a 5c",
                        PSEL, PWRITE, PENABLE, PADDR, PWDATA); end
    n_cmp++; if (FAB_RESET_N !== 1'b0 || READY !== 1'b0) begin
      n_err++; $display("FAIL cfg_fab: got %b/%b want 0/0", FAB_RESET_N, READY); end
    tick();
    n_cmp++; if ({PSEL, PENABLE, CFG_ACK} !== 3'b110) begin
      n_err++; $display("FAIL cfg_access: got %b%b%b want 110", PSEL, PENABLE, CFG_ACK); end
    tick();
    n_cmp++; if ({CFG_ACK, PSEL, PENABLE, PWRITE, PLL_ARST_N} !== 5'b10000) begin
      n_err++; $display("FAIL cfg_ack: got %b%b%b%b%b want 10000",
                        CFG_ACK, PSEL, PENABLE, PWRITE, PLL_ARST_N); end
    CFG_REQ = 1'b0;
    tick(); n = 1;
    n_cmp++; if (CFG_ACK !== 1'b0) begin
      n_err++; $display("FAIL cfg_ack_pulse: got %b want 0", CFG_ACK); end
    while (PLL_ARST_N !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== A) begin
      n_err++; $display("FAIL cfg_arst_len: got %0d want %0d", n, A); end
    wait_ready(n);
    n_cmp++; if (n !== S + 1) begin
      n_err++; $display("FAIL cfg_relock_edges: got %0d want %0d", n, S + 1); end
  endtask

  task automatic test_back_to_back();
    int n;
    LOCK = 1'b0; tick(); tick();
    CFG_ADDR = 6'h15; CFG_DATA = 8'hA7; CFG_REQ = 1'b1;
    tick();
    n_cmp++; if ({FAB_RESET_N, PSEL, LOSS_CNT} !== {2'b00, 8'd3}) begin
      n_err++; $display("FAIL b2b_loss_wins: got %b%b %0d want 00 3", FAB_RESET_N, PSEL,
                        LOSS_CNT); end
    LOCK = 1'b1; n = 0;
    do begin tick(); n++; end while (PSEL !== 1'b1 && n < 100);
    n_cmp++; if (n !== S + 4 || PADDR !== 6'h15 || PWDATA !== 8'hA7) begin
      n_err++; $display("FAIL b2b_pending: got %0d %h %h want %0d 15 a7", n, PADDR, PWDATA,
                        S + 4); end
    tick(); tick();
    n_cmp++; if (CFG_ACK !== 1'b1) begin
      n_err++; $display("FAIL b2b_ack1: got %b want 1", CFG_ACK); end
    n = 0;
    do begin tick(); n++; end while (PSEL !== 1'b1 && n < 100);
    n_cmp++; if (n !== A + S + 2) begin
      n_err++; $display("FAIL b2b_rerequest: got %0d want %0d", n, A + S + 2); end
    CFG_REQ = 1'b0;
    tick(); tick();
    n_cmp++; if (CFG_ACK !== 1'b1) begin
      n_err++; $display("FAIL b2b_ack2: got %b want 1", CFG_ACK); end
    wait_ready(n);
    n_cmp++; if (n !== A + S + 1) begin
      n_err++; $display("FAIL b2b_relock: got %0d want %0d", n, A + S + 1); end
  endtask

  task automatic test_loss_saturation();
    int n;
    for (int i = 3; i < 300; i++) begin
      LOCK = 1'b0; repeat (3) tick();
      LOCK = 1'b1; wait_ready(n);
      if (i == 254) begin
        n_cmp++; if (LOSS_CNT !== 8'd255) begin
          n_err++; $display("FAIL loss_at_255: got %0d want 255", LOSS_CNT); end
      end
    end
    n_cmp++; if (LOSS_CNT !== 8'd255 || READY !== 1'b1) begin
      n_err++; $display("FAIL loss_saturate: got %0d/%b want 255/1", LOSS_CNT, READY); end
  endtask

  task automatic test_async_reset();
    int acks;
    CFG_ADDR = 6'h03; CFG_DATA = 8'hC3; CFG_REQ = 1'b1;
    tick(); tick();
    n_cmp++; if (PENABLE !== 1'b1) begin
      n_err++; $display("FAIL arst_in_access: got %b want 1", PENABLE); end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++; if (out_vec() !== RstVec) begin
      n_err++; $display("FAIL arst_vec: got %h want %h", out_vec(), RstVec); end
    CFG_REQ = 1'b0; acks = 0;
    repeat (5) begin tick(); if (CFG_ACK === 1'b1) acks++; end
    n_cmp++; if (acks !== 0) begin
      n_err++; $display("FAIL arst_no_ack: got %0d want 0", acks); end
  endtask

  task automatic test_timeout();
    int n, pulses, extra, exp_pulses, exp_edges;
    logic prev;
`ifdef CCC_SEQ_RETRY_EN
    exp_pulses = R + 1; exp_edges = A + 1 + T + R * (A + T);
`else
    exp_pulses = 1;     exp_edges = A + 1 + T;
`endif
    LOCK = 1'b0; RESET_N = 1'b1;
    n = 0; pulses = 0; prev = PLL_ARST_N;
    while (FAULT !== 1'b1 && n < 2000) begin
      tick(); n++;
      if (PLL_ARST_N === 1'b1 && prev === 1'b0) pulses++;
      prev = PLL_ARST_N;
    end
    n_cmp++; if (pulses !== exp_pulses) begin
      n_err++; $display("FAIL timeout_pulses: got %0d want %0d", pulses, exp_pulses); end
    n_cmp++; if (n !== exp_edges) begin
      n_err++; $display("FAIL timeout_edges: got %0d want %0d", n, exp_edges); end
    n_cmp++; if ({PLL_ARST_N, FAB_RESET_N, READY} !== 3'b000) begin
      n_err++; $display("FAIL fault_outs: got %b%b%b want 000", PLL_ARST_N, FAB_RESET_N,
                        READY); end
    extra = 0;
    repeat (3 * (A + T)) begin tick(); if (PLL_ARST_N !== 1'b0) extra++; end
    n_cmp++; if (extra !== 0 || FAULT !== 1'b1) begin
      n_err++; $display("FAIL fault_sticky: got %0d/%b want 0/1", extra, FAULT); end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_lock_loss();
    test_dropout();
    test_config();
    test_back_to_back();
    test_loss_saturation();
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccc_lock_sequencer.md
# ccc_lock_sequencer

Sequencer and configuration master for the fabric CCC/PLL. It runs on the free-running RC-oscillator clock, so it never depends on the clock it controls. It pulses the PLL reset, qualifies LOCK, and releases fabric reset only after the lock is stable. It also recovers from lock loss and performs single-byte APB writes to the CCC configuration registers, each followed by a relock.

## Interface
Parameters:
- ARST_CYCLES, 16: cycles PLL_ARST_N is held low per PLL reset pulse.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-LOCK-high cycles required before release.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before timeout.
- MAX_RETRIES, 3: automatic PLL reset retries after timeout (retry feature only).
- CNT_W, 17: width of the shared cycle counter; must hold every cycle-count parameter.

Ports:
- CLK  in  1  free-running RCOSC_25_50MHZ-domain clock; also drives CCC PCLK externally.
- RESET_N  in  1  asynchronous, active-low reset.
- LOCK  in  1  CCC LOCK, asynchronous; passes through a 2-flop synchronizer (lock_s).
- PLL_ARST_N  out  1  CCC PLL reset, active-low.
- PLL_POWERDOWN_N  out  1  CCC power-down, active-low.
- PRESET_N  out  1  CCC APB reset.
- PSEL, PENABLE, PWRITE  out  1 each  CCC APB control.
- PADDR  out  6  CCC APB address.
- PWDATA  out  8  CCC APB write data.
- CFG_REQ  in  1  level request for a config write; requester holds it until CFG_ACK.
- CFG_ADDR  in  6  config register address, sampled when the request is accepted.
- CFG_DATA  in  8  config data, sampled when the request is accepted.
- CFG_ACK  out  1  one-cycle pulse; the APB write has completed.
- FAB_RESET_N  out  1  fabric reset, active-low; high only in RUN.
- READY  out  1  PLL locked and qualified.
- FAULT  out  1  sticky lock failure.
- LOSS_CNT  out  8  saturating count of lock-loss events in RUN.

## Operation
- All outputs are registered.
- Reset values:
  - PLL_ARST_N=0, PLL_POWERDOWN_N=1, PRESET_N=0
  - PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0
  - CFG_ACK=0, FAB_RESET_N=0, READY=0, FAULT=0, LOSS_CNT=0
- PRESET_N goes high on the first edge after RESET_N deasserts.
- States and transitions:
  - PLL_RST (entry after reset): PLL_ARST_N=0 for exactly ARST_CYCLES cycles, then WAIT_LOCK.
  - WAIT_LOCK: counter runs.
    - lock_s=1: go to STABLE, counter cleared.
    - Counter reaches LOCK_TIMEOUT_CYCLES: timeout (see Configuration).
  - STABLE: counts consecutive lock_s=1 cycles.
    - lock_s=0: go to WAIT_LOCK with the timeout counter restarted.
    - Count reaches LOCK_STABLE_CYCLES: go to RUN and clear the retry count.
  - RUN: READY=1, FAB_RESET_N=1.
    - lock_s=0: READY and FAB_RESET_N go to 0, LOSS_CNT increments (saturates at 255), go to WAIT_LOCK.
    - Otherwise, CFG_REQ=1: capture CFG_ADDR/CFG_DATA, go to CFG_SETUP.
  - CFG_SETUP: FAB_RESET_N=0, READY=0, PSEL=1, PWRITE=1, PENABLE=0, PADDR/PWDATA driven.
  - CFG_ACCESS: PENABLE=1 for one cycle. The CCC APB has no wait states.
    - Next cycle: PSEL/PENABLE/PWRITE=0, CFG_ACK=1 for one cycle, go to PLL_RST (relock with the new setting).
  - FAULT: FAULT=1, PLL_ARST_N=0, FAB_RESET_N=0, READY=0. Only RESET_N exits.
- If lock loss and CFG_REQ occur in the same RUN cycle, lock loss wins and the request stays pending.
- CFG_REQ outside RUN is ignored; it is served on the next RUN entry.
- If CFG_REQ is still high when RUN is re-entered after CFG_ACK, it is treated as a new request.
- Asserting RESET_N mid-operation, including mid-APB access, forces reset values immediately. An in-flight write is abandoned with no CFG_ACK.

## Timing
- LOCK to lock_s latency: 2 cycles.
- RUN lock loss: LOCK falls, FAB_RESET_N falls 3 edges later.
- Cold start:
  - PLL_ARST_N rises ARST_CYCLES+1 edges after RESET_N deasserts.
  - READY and FAB_RESET_N rise LOCK_STABLE_CYCLES+3 edges after a clean LOCK rise.
- Config write, counted from the first RUN cycle with CFG_REQ=1:
  - CFG_SETUP at +1, CFG_ACCESS at +2.
  - CFG_ACK and PLL_RST entry at +3.
- A 1-cycle LOCK dropout during STABLE restarts the full stable count.

## Configuration
- CCC_SEQ_RETRY_EN defined: on timeout with retry count < MAX_RETRIES, increment the retry count and go to PLL_RST. Otherwise go to FAULT. This gives up to MAX_RETRIES+1 PLL reset pulses per lock attempt.
- CCC_SEQ_RETRY_EN undefined: the first timeout goes to FAULT, and the retry counter logic is absent.

## Test plan
- Cold start: release RESET_N, raise LOCK 100 cycles after PLL_ARST_N rises (defaults) -> PLL_ARST_N low 16 cycles; READY=FAB_RESET_N=1 exactly 1027 edges after the LOCK rise; LOSS_CNT=0.
- Dropout: during STABLE, drop LOCK for 1 cycle at stable count 500 -> READY delayed; rises 1027 edges after LOCK returns high.
- Lock loss in RUN: LOCK falls -> FAB_RESET_N=0 3 edges later, LOSS_CNT=1, then relock to READY. Repeat 300 losses -> LOSS_CNT=255.
- Config write: in RUN, CFG_REQ=1, CFG_ADDR=6'h2A, CFG_DATA=8'h5C -> PSEL with PADDR=2A/PWDATA=5C, PENABLE on the next cycle, CFG_ACK 1-cycle pulse, then a 16-cycle PLL_ARST_N pulse, then relock to READY.
- Timeout: LOCK held at 0, macro defined -> 4 PLL_ARST_N pulses, then FAULT=1. Macro undefined -> FAULT=1 after the first 65536-cycle timeout; no further PLL_ARST_N pulses.
- Async reset: assert RESET_N during CFG_ACCESS -> all outputs at reset values before the next edge; no CFG_ACK.
